// File: rtl/glm_op_arbiter.sv
// glm_op_arbiter: round-robin sharing of one op_start/op_done unit
// between NUM_REQ issuers, with a watchdog on the WAIT phase.
module glm_op_arbiter #(
    parameter int NUM_REQ        = 4,
    parameter int TIMEOUT_CYCLES = 65536,
    parameter int TIMEOUT_WIDTH  = 32
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [NUM_REQ-1:0]     req_valid,
    input  logic [NUM_REQ*128-1:0] req_regs,
    output logic [NUM_REQ-1:0]     req_ack,
    output logic [NUM_REQ-1:0]     req_done,
    output logic [NUM_REQ-1:0]     req_error,
    output logic                   unit_op_start,
    input  logic                   unit_op_done,
    output logic [31:0]            unit_regs [4],
    output logic                   busy,
    output logic                   timeout_flag,
    output logic [31:0]            busy_cycles
);

    localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam bit WD_EN = (TIMEOUT_CYCLES != 0);
    localparam logic [TIMEOUT_WIDTH-1:0] WD_LAST =
        TIMEOUT_WIDTH'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ACK,
        S_ISSUE,
        S_WAIT,
        S_DONE
    } state_t;

    state_t                   state_q, state_d;
    logic [IW-1:0]            grant_q, grant_d;
    logic [IW-1:0]            rr_q, rr_d;
    logic [TIMEOUT_WIDTH-1:0] wd_q, wd_d;
    logic                     err_q, err_d;
    logic                     tflag_q, tflag_d;
    logic [31:0]              bcnt_q;
    logic [31:0]              regs_q [4];
    logic                     load;
    logic                     found;
    logic [IW-1:0]            gsel;

    // First requester after the last grant, wrapping modulo NUM_REQ
    always_comb begin
        found = 1'b0;
        gsel  = '0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            if (!found && req_valid[(int'(rr_q) + i) % NUM_REQ]) begin
                found = 1'b1;
                gsel  = IW'((int'(rr_q) + i) % NUM_REQ);
            end
        end
    end

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        rr_d    = rr_q;
        wd_d    = wd_q;
        err_d   = err_q;
        tflag_d = tflag_q;
        load    = 1'b0;
        unique case (state_q)
            S_IDLE, S_DONE: begin
                err_d = 1'b0;
                if (found) begin
                    state_d = S_ACK;
                    grant_d = gsel;
                    rr_d    = gsel;
                    load    = 1'b1;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_ACK: state_d = S_ISSUE;
            S_ISSUE: begin
                wd_d    = '0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (unit_op_done) begin
                    state_d = S_DONE;
                    err_d   = 1'b0;
                end else if (WD_EN && wd_q == WD_LAST) begin
                    state_d = S_DONE;
                    err_d   = 1'b1;
                    tflag_d = 1'b1;
                end else begin
                    wd_d = wd_q + 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            grant_q <= '0;
            rr_q    <= IW'(NUM_REQ - 1);
            wd_q    <= '0;
            err_q   <= 1'b0;
            tflag_q <= 1'b0;
            bcnt_q  <= '0;
            for (int w = 0; w < 4; w++) regs_q[w] <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            rr_q    <= rr_d;
            wd_q    <= wd_d;
            err_q   <= err_d;
            tflag_q <= tflag_d;
            bcnt_q  <= bcnt_q + 32'(busy);
            if (load) begin
                for (int w = 0; w < 4; w++)
                    regs_q[w] <= req_regs[int'(gsel)*128 + w*32 +: 32];
            end
        end
    end

    always_comb begin
        req_ack   = '0;
        req_done  = '0;
        req_error = '0;
        if (state_q == S_ACK) req_ack[grant_q] = 1'b1;
        if (state_q == S_DONE) begin
            req_done[grant_q]  = 1'b1;
            req_error[grant_q] = err_q;
        end
    end

    assign unit_op_start = (state_q == S_ISSUE);
    assign busy          = (state_q != S_IDLE);
    assign timeout_flag  = tflag_q;
    assign busy_cycles   = bcnt_q;
    assign unit_regs     = regs_q;

endmodule

// File: tb/tb_glm_op_arbiter.sv
// Randomized scoreboard bench for glm_op_arbiter: expected grants are
// queued at issue time and popped by a monitor on ack/done pulses.
module tb_glm_op_arbiter;

    localparam int N  = 4;
    localparam int TO = 24;

    logic           clk = 1'b0;
    logic           reset = 1'b0;
    logic [N-1:0]   req_valid = '0;
    logic [N*128-1:0] req_regs = '0;
    logic [N-1:0]   req_ack, req_done, req_error;
    logic           unit_op_start;
    logic           unit_op_done = 1'b0;
    logic [31:0]    unit_regs [4];
    logic           busy, timeout_flag;
    logic [31:0]    busy_cycles;

    glm_op_arbiter #(
        .NUM_REQ(N),
        .TIMEOUT_CYCLES(TO),
        .TIMEOUT_WIDTH(32)
    ) dut (
        .clk(clk),
        .reset(reset),
        .req_valid(req_valid),
        .req_regs(req_regs),
        .req_ack(req_ack),
        .req_done(req_done),
        .req_error(req_error),
        .unit_op_start(unit_op_start),
        .unit_op_done(unit_op_done),
        .unit_regs(unit_regs),
        .busy(busy),
        .timeout_flag(timeout_flag),
        .busy_cycles(busy_cycles)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int         idx;
        logic [127:0] b;
        int         lat;
        int         at;
        bit         err;
    } exp_t;

    exp_t ack_q[$];
    exp_t own_q[$];
    exp_t done_q[$];

    int nchk = 0;
    int nerr = 0;

    int   mdl_last  = N - 1;
    bit   mdl_tflag = 1'b0;
    bit   unit_busy = 1'b0;
    bit   force_done = 1'b0;
    exp_t cur;
    int   st, done_at;
    bit   rereq [N];
    logic [127:0] rereq_b [N];

    function automatic void chk(string nm, logic [127:0] got,
                                logic [127:0] exp);
        nchk++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)",
                     nm, got, exp, cyc);
        end
    endfunction

    function automatic logic [N-1:0] oh(input int i);
        logic [N-1:0] v;
        v    = '0;
        v[i] = 1'b1;
        return v;
    endfunction

    function automatic logic [127:0] ureg();
        return {unit_regs[3], unit_regs[2], unit_regs[1], unit_regs[0]};
    endfunction

    // Monitor: compares every ack/done pulse against the queued expectation
    always @(negedge clk) begin : mon
        exp_t e;
        if (reset) begin
            if (req_ack != '0) begin
                if (ack_q.size() == 0) begin
                    chk("ack_unexpected", 128'(req_ack), 128'(0));
                end else begin
                    e = ack_q.pop_front();
                    chk("ack_vec", 128'(req_ack), 128'(oh(e.idx)));
                    chk("ack_regs", ureg(), e.b);
                    if (e.at >= 0) chk("ack_cycle", cyc, e.at);
                end
            end
            if (req_done != '0) begin
                if (done_q.size() == 0) begin
                    chk("done_unexpected", 128'(req_done), 128'(0));
                end else begin
                    e = done_q.pop_front();
                    chk("done_vec", 128'(req_done), 128'(oh(e.idx)));
                    chk("error_vec", 128'(req_error),
                        e.err ? 128'(oh(e.idx)) : 128'(0));
                    chk("done_cycle", cyc, e.at);
                    chk("done_regs", ureg(), e.b);
                end
            end else if (req_error != '0) begin
                chk("error_without_done", 128'(req_error), 128'(0));
            end
        end
    end

    // One cycle of issuer and unit behaviour
    task automatic tick();
        exp_t d;
        @(negedge clk);
        unit_op_done = force_done;
        force_done   = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (req_ack[i]) req_valid[i] = 1'b0;
            if (req_done[i] && rereq[i]) begin
                rereq[i] = 1'b0;
                req_regs[i*128 +: 128] = rereq_b[i];
                req_valid[i] = 1'b1;
            end
        end
        if (unit_op_start) begin
            chk("start_overlap", 128'(unit_busy), 128'(0));
            if (own_q.size() == 0) begin
                chk("start_unexpected", 128'(1), 128'(0));
            end else begin
                cur = own_q.pop_front();
                if (cur.at >= 0) chk("start_cycle", cyc, cur.at + 1);
                st        = cyc;
                unit_busy = 1'b1;
                d.idx = cur.idx;
                d.b   = cur.b;
                d.lat = cur.lat;
                if (cur.lat >= 1 && cur.lat <= TO) begin
                    d.err = 1'b0;
                    d.at  = st + cur.lat + 1;
                end else begin
                    d.err = 1'b1;
                    d.at  = st + TO + 1;
                    mdl_tflag = 1'b1;
                end
                done_at = d.at;
                done_q.push_back(d);
            end
        end
        if (unit_busy && cur.lat > 0 && cyc == st + cur.lat)
            unit_op_done = 1'b1;
        if (unit_busy && cyc >= done_at) unit_busy = 1'b0;
    endtask

    task automatic expect_grant(input int i, input logic [127:0] b,
                                input int lat, input int at);
        exp_t e;
        e.idx = i;
        e.b   = b;
        e.lat = lat;
        e.at  = at;
        e.err = 1'b0;
        ack_q.push_back(e);
        own_q.push_back(e);
        mdl_last = i;
    endtask

    task automatic drive(input int i, input logic [127:0] b);
        req_regs[i*128 +: 128] = b;
        req_valid[i] = 1'b1;
    endtask

    // Raise all requesters in mask at once while the arbiter is idle;
    // they are served in cyclic order after the last grant.
    task automatic issue(input logic [N-1:0] mask, input int lat);
        int base, i, l, at;
        logic [127:0] b;
        base = mdl_last;
        at   = cyc + 1;
        for (int s = 1; s <= N; s++) begin
            i = (base + s) % N;
            if (mask[i]) begin
                l = lat;
                if (l < 0)
                    l = ($urandom_range(0, 9) == 0) ? 0
                        : int'($urandom_range(1, TO));
                b = {$urandom(), $urandom(), $urandom(), $urandom()};
                expect_grant(i, b, l, at);
                drive(i, b);
                at = -1;
            end
        end
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((ack_q.size() != 0 || own_q.size() != 0 ||
                done_q.size() != 0 || unit_busy || req_valid != '0)
               && n < 3000) begin
            tick();
            n++;
        end
        chk("drain_in_time", 128'(n < 3000), 128'(1));
        tick();
        tick();
    endtask

    task automatic chk_quiet(string nm);
        chk({nm, "_busy"}, 128'(busy), 128'(0));
        chk({nm, "_ack"}, 128'(req_ack), 128'(0));
        chk({nm, "_done"}, 128'(req_done), 128'(0));
        chk({nm, "_err"}, 128'(req_error), 128'(0));
        chk({nm, "_start"}, 128'(unit_op_start), 128'(0));
        chk({nm, "_tflag"}, 128'(timeout_flag), 128'(0));
        chk({nm, "_bcnt"}, 128'(busy_cycles), 128'(0));
        chk({nm, "_uregs"}, ureg(), 128'(0));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [127:0] b1, b3, b1b;
        logic [N-1:0] m;
        for (int i = 0; i < N; i++) begin
            rereq[i]   = 1'b0;
            rereq_b[i] = '0;
        end
        repeat (3) @(negedge clk);
        chk_quiet("reset");
        reset = 1'b1;
        tick();

        // Single request with a fixed bundle and 20-cycle unit latency
        expect_grant(2, {32'h0008_0010, 32'h3, 32'h2, 32'h1}, 20, cyc + 1);
        drive(2, {32'h0008_0010, 32'h3, 32'h2, 32'h1});
        wait_idle();
        chk("single_busy_cycles", 128'(busy_cycles), 128'(23));
        chk("single_tflag", 128'(timeout_flag), 128'(0));

        // All four requesting, 5-cycle unit
        issue(4'b1111, 5);
        wait_idle();

        // Requester 1 re-requests on its done while 3 is still waiting
        issue(4'b0001, 4);
        wait_idle();
        b1  = {$urandom(), $urandom(), $urandom(), $urandom()};
        b3  = {$urandom(), $urandom(), $urandom(), $urandom()};
        b1b = {$urandom(), $urandom(), $urandom(), $urandom()};
        expect_grant(1, b1, 6, cyc + 1);
        expect_grant(3, b3, 6, -1);
        expect_grant(1, b1b, 6, -1);
        drive(1, b1);
        drive(3, b3);
        rereq[1]   = 1'b1;
        rereq_b[1] = b1b;
        wait_idle();

        // Random masks, latencies and occasional watchdog aborts
        for (int r = 0; r < 12; r++) begin
            m = N'($urandom_range(1, (1 << N) - 1));
            issue(m, -1);
            wait_idle();
        end
        chk("random_tflag", 128'(timeout_flag), 128'(mdl_tflag));

        // Watchdog abort, then a normal op keeps the sticky flag
        issue(4'b1000, 0);
        wait_idle();
        chk("wd_tflag", 128'(timeout_flag), 128'(1));
        issue(4'b0011, 3);
        wait_idle();
        chk("wd_tflag_sticky", 128'(timeout_flag), 128'(1));

        // Done on the last watchdog cycle wins; spurious done in idle ignored
        issue(4'b0100, TO);
        wait_idle();
        force_done = 1'b1;
        tick();
        tick();
        tick();
        chk("spurious_done", 128'(req_done), 128'(0));
        chk("spurious_busy", 128'(busy), 128'(0));

        // Asynchronous reset in the middle of WAIT
        issue(4'b0010, 0);
        repeat (8) tick();
        chk("pre_reset_busy", 128'(busy), 128'(1));
        #2 reset = 1'b0;
        #1;
        chk_quiet("midwait_reset");
        ack_q.delete();
        own_q.delete();
        done_q.delete();
        unit_busy    = 1'b0;
        unit_op_done = 1'b0;
        req_valid    = '0;
        mdl_last     = N - 1;
        mdl_tflag    = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        repeat (30) tick();
        chk("post_reset_done", 128'(req_done), 128'(0));
        chk("post_reset_bcnt", 128'(busy_cycles), 128'(0));
        issue(4'b1111, 2);
        wait_idle();
        chk("final_tflag", 128'(timeout_flag), 128'(mdl_tflag));

        $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
        $finish;
    end

endmodule

// File: doc/glm_op_arbiter.md
Name: glm_op_arbiter

Overview:
- Shares one op_start/op_done compute unit (e.g. the GLM delta subtract engine) between NUM_REQ instruction issuers.
- Each issuer presents a 4x32 register bundle and a request. The arbiter grants round-robin and latches the granted bundle into the unit's regs. It then pulses op_start, waits for op_done (with a watchdog), and returns a completion pulse to the granted issuer.
- Sits between the per-pipeline instruction decoders and the shared unit.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- TIMEOUT_CYCLES, 65536, maximum WAIT cycles before abort. 0 disables the watchdog.
- TIMEOUT_WIDTH, 32, width of the watchdog counter.

Ports:
- clk  in  1  clock; all logic on rising edge.
- reset  in  1  asynchronous, active-low reset.
- req_valid  in  NUM_REQ  level request per issuer.
- req_regs  in  NUM_REQ*128  per-issuer bundle. Issuer i occupies bits [128i+127:128i]; word w is bits [128i+32w+31 : 128i+32w].
- req_ack  out  NUM_REQ  one-cycle pulse: bundle captured, issuer may change req_regs.
- req_done  out  NUM_REQ  one-cycle pulse: operation finished.
- req_error  out  NUM_REQ  one-cycle pulse coincident with req_done on watchdog abort.
- unit_op_start  out  1  one-cycle start pulse to the shared unit.
- unit_op_done  in  1  one-cycle completion pulse from the unit.
- unit_regs  out  4x32  unpacked array; bundle of the current grant, held stable from ack through done.
- busy  out  1  high in any state other than IDLE.
- timeout_flag  out  1  sticky; set on any watchdog abort, cleared only by reset.
- busy_cycles  out  32  count of cycles with busy=1; wraps at 2^32.

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE; rr_ptr=NUM_REQ-1, so requester 0 has top priority.
  - All pulse outputs 0; unit_regs=0; timeout_flag=0; busy_cycles=0; watchdog=0.
  - Reset mid-operation abandons the grant silently: no req_done, no req_error.
- States and transitions:
  - IDLE: at a clock edge where any req_valid bit is 1, select the first set bit scanning rr_ptr+1, rr_ptr+2, … modulo NUM_REQ, giving index g.
    - Register g; rr_ptr<=g; unit_regs<=req_regs[g].
    - req_ack[g]=1 in the following cycle; go to ISSUE.
    - No valid bits: stay in IDLE, all outputs quiet.
  - ISSUE (1 cycle): unit_op_start=1; watchdog<=0; go to WAIT.
  - WAIT:
    - unit_op_done=1: req_done[g]=1 next cycle, go to IDLE.
    - Else if TIMEOUT_CYCLES!=0 and watchdog==TIMEOUT_CYCLES-1: req_done[g]=1 and req_error[g]=1 next cycle; timeout_flag<=1; go to IDLE.
    - Otherwise watchdog increments.
    - op_done and timeout in the same cycle: done wins, no error.
- Latency:
  - Request sampled at edge k: req_ack in cycle k+1, unit_op_start in cycle k+2.
  - op_done in cycle m gives req_done in cycle m+1. The next grant can be sampled at the end of m+1, so ack at m+2 earliest.
- Other rules:
  - unit_op_done outside WAIT is ignored; it does not cause req_done.
  - Requests are not queued. An issuer holds req_valid and req_regs until req_ack, and must deassert req_valid on the ack cycle or it is re-granted.
  - An issuer dropping req_valid before being granted loses its request silently.
  - Fairness: with all requesters asserting continuously, grants cycle 0,1,…,NUM_REQ-1,0.
  - busy = (state != IDLE); the ack cycle counts as busy.
  - Width: req_ack/req_done/req_error are one-hot or zero, never multiple bits set.

Test Plan:
- Single request: reset, then req_valid=4'b0100 with regs {32'h1, 32'h2, 32'h3, 32'h0008_0010} at edge 10.
  - req_ack=4'b0100 in cycle 11; unit_op_start in cycle 12; unit_regs match the bundle.
  - Model unit_op_done 20 cycles later: req_done=4'b0100 one cycle after; busy_cycles=23.
- Round-robin: all four requesters held high and each deasserts on its ack; unit model with 5-cycle latency.
  - Ack order 0,1,2,3; unit_op_start never overlaps an outstanding op.
- Fairness with re-request: requester 1 re-requests immediately after its done while requester 3 waits.
  - Requester 3 is granted before requester 1's second grant.
- Watchdog: TIMEOUT_CYCLES=16, unit never asserts done.
  - req_done and req_error for the grantee exactly 17 cycles after unit_op_start; timeout_flag=1 and stays 1 across a later successful op.
- Boundary: unit_op_done on the watchdog's final WAIT cycle gives req_done only, req_error=0. A spurious unit_op_done in IDLE gives no req_done.
- Reset mid-WAIT: reset=0 asynchronously.
  - All outputs 0 immediately; no req_done after release; the next grant goes to requester 0 when all request.
